// File: rtl/mips_serial_tx_ctrl.sv
// Serial output sequencer: buffers 32-bit words from the MIPS core and feeds them
// to the byte-wide UART transmitter, most significant byte first.
module mips_serial_tx_ctrl #(
    parameter int WORD_LENGTH = 32,
    parameter int NBITS       = 8,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   SerialOutEn,
    input  logic [WORD_LENGTH-1:0] SerialData,
    input  logic                   TX_flag,
    output logic                   tx_start,
    output logic [NBITS-1:0]       tx_data,
    output logic                   full,
    output logic                   empty,
    output logic                   busy,
    output logic                   overflow
);

    localparam int BPW   = WORD_LENGTH / NBITS;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    state_t                 state;
    logic [WORD_LENGTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [WORD_LENGTH-1:0] shreg;
    logic [BC_W-1:0]        byte_cnt;

    logic is_full;
    logic do_push;
    logic do_pop;

    // A write into a full FIFO is dropped even if a pop frees a slot on the same edge.
    assign is_full = (count == CNT_W'(DEPTH));
    assign do_push = SerialOutEn && !is_full;
    assign do_pop  = (state == IDLE) && start && (count != '0);

    assign tx_start = (state == SEND);
    assign busy     = (state != IDLE);
    assign full     = is_full;
    assign empty    = (count == '0);
    assign tx_data  = shreg[WORD_LENGTH-1 -: NBITS];

    // Storage needs no reset: count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= SerialData;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            shreg    <= '0;
            byte_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
            if (SerialOutEn && is_full) begin
                overflow <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (do_pop) begin
                        shreg    <= mem[rd_ptr];
                        byte_cnt <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (TX_flag) begin
                        if (byte_cnt == BC_W'(BPW - 1)) begin
                            state <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + BC_W'(1);
                            shreg    <= shreg << NBITS;
                            state    <= SEND;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_serial_tx_ctrl.sv
// Directed bench for mips_serial_tx_ctrl: byte order, FIFO limits, start gating,
// stray completion pulses and asynchronous reset.
module tb_mips_serial_tx_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        SerialOutEn;
    logic [31:0] SerialData;
    logic        TX_flag;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        full;
    logic        empty;
    logic        busy;
    logic        overflow;

    logic        resp_flag;
    logic        man_flag;
    logic        resp_en = 1'b0;
    int unsigned resp_delay = 1;

    int unsigned total = 0;
    int unsigned bad = 0;
    int unsigned cyc = 0;
    int unsigned b2b_cnt = 0;
    logic        prev_tx = 1'b0;
    logic [7:0]  cap_q[$];
    int unsigned stamp_q[$];
    int unsigned base;

    always #5 clk = ~clk;
    assign TX_flag = resp_flag | man_flag;

    mips_serial_tx_ctrl #(
        .WORD_LENGTH(32),
        .NBITS(8),
        .DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .SerialOutEn(SerialOutEn),
        .SerialData(SerialData),
        .TX_flag(TX_flag),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .full(full),
        .empty(empty),
        .busy(busy),
        .overflow(overflow)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every transmitted byte; flag back-to-back or out-of-FSM requests.
    always @(negedge clk) begin
        if (tx_start) begin
            cap_q.push_back(tx_data);
            stamp_q.push_back(cyc);
            if (prev_tx || !busy) b2b_cnt++;
        end
        prev_tx = tx_start;
    end

    // UART model: completion pulse resp_delay cycles after each request.
    initial begin
        resp_flag = 1'b0;
        forever begin
            @(negedge clk);
            while (resp_en && tx_start) begin
                repeat (resp_delay) @(negedge clk);
                resp_flag = 1'b1;
                @(negedge clk);
                resp_flag = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic write_word(input logic [31:0] w);
        SerialOutEn = 1'b1;
        SerialData  = w;
        @(negedge clk);
        SerialOutEn = 1'b0;
    endtask

    task automatic pulse_man;
        man_flag = 1'b1;
        @(negedge clk);
        man_flag = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int unsigned budget);
        int unsigned n = 0;
        while ((busy || !empty) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, {30'd0, busy, empty}, 32'd1);
    endtask

    task automatic check_word(input string tag, input int unsigned idx, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] exp_b;
            logic [7:0] got_b;
            exp_b = w[31 - 8*i -: 8];
            got_b = (idx + i < cap_q.size()) ? cap_q[idx + i] : 8'hxx;
            check(tag, {24'd0, got_b}, {24'd0, exp_b});
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; SerialOutEn = 1'b0; SerialData = '0; man_flag = 1'b0;
        #12;
        check("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_flags", {28'd0, full, empty, busy, overflow}, 32'b0100);
        @(negedge clk);
        reset = 1'b0;

        // Single word, slow UART
        start = 1'b1; resp_delay = 3; resp_en = 1'b1;
        base = cap_q.size();
        write_word(32'hA1B2C3D4);
        check("t1_after_write", {29'd0, empty, busy, tx_start}, 32'b000);
        @(negedge clk);
        check("t1_pop", {29'd0, empty, busy, tx_start}, 32'b111);
        check("t1_first_byte", {24'd0, tx_data}, 32'hA1);
        wait_idle("t1_idle", 200);
        check("t1_count", cap_q.size() - base, 32'd4);
        check_word("t1_bytes", base, 32'hA1B2C3D4);
        check("t1_gap", stamp_q[base+1] - stamp_q[base], 32'd4);
        check("t1_overflow", {31'd0, overflow}, 32'd0);

        // Back-to-back words, repeated to wrap pointers
        resp_delay = 1;
        for (int r = 0; r < 6; r++) begin
            base = cap_q.size();
            write_word(32'h11223344);
            write_word(32'h55667788);
            wait_idle("t2_idle", 200);
            check("t2_count", cap_q.size() - base, 32'd8);
            check_word("t2_w0", base, 32'h11223344);
            check_word("t2_w1", base + 4, 32'h55667788);
            check("t2_gap_in_word", stamp_q[base+1] - stamp_q[base], 32'd2);
            check("t2_gap_between", stamp_q[base+4] - stamp_q[base+3], 32'd3);
        end

        // Full and overflow with the UART stalled
        resp_en = 1'b0;
        base = cap_q.size();
        for (int k = 1; k <= 5; k++) begin
            write_word(32'(k));
            if (k == 4) check("t3_not_full_4", {31'd0, full}, 32'd0);
        end
        check("t3_full_5", {30'd0, full, overflow}, 32'b10);
        write_word(32'd6);
        check("t3_ovf_6", {30'd0, full, overflow}, 32'b11);
        resp_en = 1'b1;
        pulse_man();
        wait_idle("t3_idle", 1000);
        check("t3_count", cap_q.size() - base, 32'd20);
        for (int k = 0; k < 5; k++) check_word("t3_bytes", base + 4*k, 32'(k + 1));
        check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t3_ovf_cleared", {30'd0, overflow, empty}, 32'b01);

        // start gating
        start = 1'b0;
        base = cap_q.size();
        write_word(32'hDEADBEEF);
        repeat (20) @(negedge clk);
        check("t4_held", cap_q.size() - base, 32'd0);
        check("t4_held_flags", {30'd0, empty, busy}, 32'b00);
        start = 1'b1;
        @(negedge clk);
        check("t4_start_tx", {23'd0, tx_start, tx_data}, {23'd0, 1'b1, 8'hDE});
        for (int n = 0; n < 50 && cap_q.size() < base + 2; n++) @(negedge clk);
        start = 1'b0;
        wait_idle("t4_idle", 200);
        check("t4_count", cap_q.size() - base, 32'd4);
        check_word("t4_bytes", base, 32'hDEADBEEF);

        // Stray TX_flag in IDLE and in SEND
        start = 1'b1;
        base = cap_q.size();
        pulse_man();
        @(negedge clk);
        check("t5_idle_stray", {30'd0, busy, tx_start}, 32'b00);
        check("t5_idle_nobyte", cap_q.size() - base, 32'd0);
        resp_en = 1'b0;
        write_word(32'h01020304);
        @(negedge clk);
        check("t5_send", {31'd0, tx_start}, 32'd1);
        pulse_man();
        check("t5_send_stray", {22'd0, busy, tx_start, tx_data}, {22'd0, 1'b1, 1'b0, 8'h01});
        repeat (4) @(negedge clk);
        check("t5_no_advance", cap_q.size() - base, 32'd1);
        check("t5_data_held", {23'd0, tx_start, tx_data}, {23'd0, 1'b0, 8'h01});
        resp_en = 1'b1;
        pulse_man();
        wait_idle("t5_idle", 200);
        check("t5_count", cap_q.size() - base, 32'd4);
        check_word("t5_bytes", base, 32'h01020304);

        // Asynchronous reset during WAIT of byte 2
        resp_en = 1'b0;
        write_word(32'hCAFEF00D);
        write_word(32'h12345678);
        check("t6_byte1", {23'd0, tx_start, tx_data}, {23'd0, 1'b1, 8'hCA});
        @(negedge clk);
        pulse_man();
        check("t6_byte2", {23'd0, tx_start, tx_data}, {23'd0, 1'b1, 8'hFE});
        @(negedge clk);
        check("t6_wait", {29'd0, busy, tx_start, empty}, 32'b100);
        #2 reset = 1'b1;
        #1;
        check("t6_async_flags", {28'd0, tx_start, busy, empty, full}, 32'b0010);
        check("t6_async_data", {24'd0, tx_data}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        resp_en = 1'b1;
        base = cap_q.size();
        repeat (20) @(negedge clk);
        check("t6_silent", cap_q.size() - base, 32'd0);
        check("t6_silent_flags", {30'd0, busy, empty}, 32'b01);
        write_word(32'h9ABCDEF0);
        wait_idle("t6_idle", 200);
        check("t6_count", cap_q.size() - base, 32'd4);
        check_word("t6_bytes", base, 32'h9ABCDEF0);

        check("no_back_to_back", b2b_cnt, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mips_serial_tx_ctrl.md
# mips_serial_tx_ctrl

Sequencing controller between the MIPS core's serial output port (SerialOutEn/SerialData) and the byte-wide UART transmitter. Buffers 32-bit words written by the core in a small FIFO, splits each word into NBITS-wide bytes, most significant byte first, and issues one transmit request per byte. It then waits for the transmitter's TX_flag completion pulse before sending the next byte. Sits at the MIPS top level in place of the direct SerialData-to-UART connection.

## Interface

- WORD_LENGTH, 32, width of words from the core; must be a multiple of NBITS
- NBITS, 8, UART byte width
- DEPTH, 4, FIFO depth in words; power of two, at least 2
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  transmit enable level; while low, no new word is started
- SerialOutEn  in  1  one-cycle write strobe from core
- SerialData  in  WORD_LENGTH  word to transmit, valid with SerialOutEn
- TX_flag  in  1  one-cycle pulse from UART: current byte finished
- tx_start  out  1  one-cycle request to UART to send tx_data
- tx_data  out  NBITS  byte to send; stable from tx_start until TX_flag
- full  out  1  FIFO holds DEPTH words
- empty  out  1  FIFO holds 0 words
- busy  out  1  FSM not in IDLE
- overflow  out  1  sticky: a write was dropped because FIFO was full

## Operation

- BPW = WORD_LENGTH/NBITS bytes per word (4 at defaults).
- FIFO:
  - circular buffer with wr_ptr, rd_ptr, and count (0..DEPTH).
  - A write when count==DEPTH is dropped and sets overflow. This holds even if a pop occurs on the same edge.
  - Otherwise a push and a pop on the same edge leave count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE: if start==1 and count!=0, pop the head word into a WORD_LENGTH shift register, clear byte_cnt, and go to SEND.
  - SEND: tx_start=1 for exactly this cycle; go to WAIT unconditionally. TX_flag seen in SEND is ignored.
  - WAIT: on TX_flag, if byte_cnt==BPW-1 go to IDLE. Otherwise increment byte_cnt, shift the register left by NBITS, and go to SEND.
  - TX_flag in IDLE is ignored.
- tx_data = shift register bits [WORD_LENGTH-1 -: NBITS]. It changes only on the pop edge and on the shift edges.
- start going low mid-word does not abort; the current word completes and the FSM then holds in IDLE.
- Writes are accepted regardless of start or FSM state.
- Outputs:
  - tx_start, busy: decoded from the state register.
  - full, empty: decoded from count.
  - overflow, tx_data: registered.

## Timing

- Reset values:
  - state=IDLE, count=0, pointers=0, shift register=0, byte_cnt=0.
  - tx_start=0, tx_data=0, full=0, empty=1, busy=0, overflow=0.
- Reset asserted mid-word forces every value above immediately (asynchronous). Any in-flight byte is abandoned, buffered words are discarded, and no TX_flag is awaited after release.
- Latency, with start=1 and the FSM in IDLE:
  - Write strobe sampled at edge E0: count=1 and empty=0 after E0.
  - Pop at E1: count=0, empty=1, busy=1, tx_start=1 during cycle E1..E2, with tx_data holding the first byte.
- Per byte: TX_flag sampled at edge Ek moves the FSM to SEND, and tx_start rises in the cycle after Ek. This gives a minimum of 2 cycles from one tx_start to the next.
- Last byte: TX_flag edge returns the FSM to IDLE (busy=0). If the FIFO is non-empty and start=1, the next word pops on the following edge.
- tx_start never asserts on consecutive cycles and never asserts while in WAIT.

## Test plan

- Single word, basic sequencing:
  - Stimulus: reset, start=1, write 0xA1B2C3D4, pulse TX_flag 3 cycles after each tx_start.
  - Expect exactly 4 tx_start pulses carrying tx_data 0xA1, 0xB2, 0xC3, 0xD4 in order, then busy=0, empty=1, overflow=0.
- Back-to-back words across pointer wrap:
  - Stimulus: write 0x11223344 then 0x55667788 on consecutive cycles, answer every tx_start with TX_flag.
  - Expect 8 bytes 11,22,33,44,55,66,77,88 and a single IDLE cycle between words.
  - Repeat 6 times to wrap the pointers.
- Full and overflow:
  - Stimulus: start=1, never pulse TX_flag, write 6 words 0x00000001..0x00000006 on consecutive cycles.
  - Word 1 pops. Expect full=1 after the 5th write; the 6th write is dropped and sets overflow=1.
  - After releasing TX_flag, the bytes of words 1–5 appear and word 6 never does. overflow stays 1 until reset.
- start gating:
  - Stimulus: start=0, write 0xDEADBEEF.
  - Expect no tx_start and empty=0 for 20 cycles.
  - Raise start: tx_start follows on the next edge with 0xDE. Dropping start after the 2nd byte still yields BE, EF.
- Stray TX_flag:
  - Stimulus: pulse TX_flag in IDLE and in the SEND cycle.
  - Expect no state change, no byte advance, and no extra tx_start.
- Reset mid-operation:
  - Stimulus: assert reset asynchronously between edges during the WAIT of byte 2 of 0xCAFEF00D, with one more word buffered.
  - Expect tx_start=0, busy=0, empty=1, tx_data=0 immediately, before the next edge.
  - After release, no bytes are sent until a new write.
